// File: rtl/ddr4_phy_tri_dly_pkg.sv
// Shared types for the tristate ODELAY tap sequencer.
// Holds the request opcodes, sequencer states, tap limits and a sizing helper.
package ddr4_phy_tri_dly_pkg;

   localparam int DLY_TAP_W = 9;
   localparam int TAP_MAX   = (1 << DLY_TAP_W) - 1;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_READ = 2'b11
   } dly_op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_VTC_OFF,
      S_LOAD,
      S_STEP,
      S_GAP,
      S_SETTLE,
      S_SAMPLE,
      S_VTC_ON,
      S_RESP
   } dly_seq_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ddr4_phy_tri_dly_wait_timer.sv
// Loadable down-counter with a done flag, shared by all wait states.
// Ports: clk, rst_n (sync, active low), load/load_val (restart), done (count at zero).
module ddr4_phy_tri_dly_wait_timer #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/ddr4_phy_tri_dly_seq.sv
// Tap-request sequencer for one tristate bitslice ODELAY port.
// Ports: req_* (op in), rsp_* (tap/err out), dly_* (bitslice ODELAY control), busy.
module ddr4_phy_tri_dly_seq
   import ddr4_phy_tri_dly_pkg::*;
#(
   parameter int TAP_W     = DLY_TAP_W,
   parameter int VTC_WAIT  = 10,
   parameter int STEP_GAP  = 4,
   parameter int LD_SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [TAP_W-1:0] req_val,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [TAP_W-1:0] rsp_tap,
   output logic             rsp_err,
   output logic             dly_ce,
   output logic             dly_inc,
   output logic             dly_ld,
   output logic [TAP_W-1:0] dly_cntvaluein,
   input  logic [TAP_W-1:0] dly_cntvalueout,
   output logic             dly_en_vtc,
   output logic             busy
);

   localparam int CW = $clog2(max3(VTC_WAIT, STEP_GAP, LD_SETTLE)) + 1;
   localparam logic [TAP_W:0] CNT_MAX = {1'b0, {TAP_W{1'b1}}};

   dly_seq_state_e   state;
   dly_op_e          op;
   logic [TAP_W-1:0] val;
   logic [TAP_W-1:0] steps;
   logic             clamp;
   logic             accept;

   logic [TAP_W:0]   cur_w;
   logic [TAP_W:0]   val_w;
   logic [TAP_W:0]   room;
   logic [TAP_W:0]   n_w;
   logic             n_clamp;

   logic             tmr_load;
   logic [CW-1:0]    tmr_val;
   logic             tmr_done;

   assign accept = req_valid && req_ready;
   assign busy   = (state != S_IDLE);

   // Step count limited against the live tap so a ce never wraps the delay line.
   always_comb begin
      cur_w = {1'b0, dly_cntvalueout};
      val_w = {1'b0, req_val};
      room  = CNT_MAX - cur_w;
      n_w   = val_w;
      unique case (dly_op_e'(req_op))
         OP_INC:  if (val_w > room)  n_w = room;
         OP_DEC:  if (val_w > cur_w) n_w = cur_w;
         default: n_w = val_w;
      endcase
      n_clamp = (n_w != val_w);
   end

   // Timer is reloaded on the edge that enters VTC_OFF, GAP or SETTLE.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state)
         S_IDLE: begin
            if (accept && (dly_op_e'(req_op) != OP_READ)) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(VTC_WAIT - 1);
            end
         end
         S_VTC_OFF: begin
            if (tmr_done && (op != OP_LOAD) && (steps == '0)) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(LD_SETTLE - 1);
            end
         end
         S_LOAD: begin
            tmr_load = 1'b1;
            tmr_val  = CW'(LD_SETTLE - 1);
         end
         S_STEP: begin
            tmr_load = 1'b1;
            if (steps > TAP_W'(1)) tmr_val = CW'(STEP_GAP - 2);
            else                   tmr_val = CW'(LD_SETTLE - 1);
         end
         default: begin
            tmr_load = 1'b0;
            tmr_val  = '0;
         end
      endcase
   end

   ddr4_phy_tri_dly_wait_timer #(
      .CW(CW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .load_val(tmr_val),
      .done    (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         op             <= OP_READ;
         val            <= '0;
         steps          <= '0;
         clamp          <= 1'b0;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_tap        <= '0;
         rsp_err        <= 1'b0;
         dly_ce         <= 1'b0;
         dly_inc        <= 1'b0;
         dly_ld         <= 1'b0;
         dly_cntvaluein <= '0;
         dly_en_vtc     <= 1'b1;
      end else begin
         dly_ce <= 1'b0;
         dly_ld <= 1'b0;
         unique case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  op        <= dly_op_e'(req_op);
                  val       <= req_val;
                  steps     <= n_w[TAP_W-1:0];
                  clamp     <= n_clamp;
                  if (dly_op_e'(req_op) == OP_READ) begin
                     state <= S_SAMPLE;
                  end else begin
                     state      <= S_VTC_OFF;
                     dly_en_vtc <= 1'b0;
                  end
               end
            end
            S_VTC_OFF: begin
               if (tmr_done) begin
                  if (op == OP_LOAD) begin
                     state          <= S_LOAD;
                     dly_ld         <= 1'b1;
                     dly_cntvaluein <= val;
                  end else if (steps == '0) begin
                     state <= S_SETTLE;
                  end else begin
                     state   <= S_STEP;
                     dly_ce  <= 1'b1;
                     dly_inc <= (op == OP_INC);
                  end
               end
            end
            S_LOAD: begin
               state <= S_SETTLE;
            end
            S_STEP: begin
               steps <= steps - 1'b1;
               if (steps > TAP_W'(1)) state <= S_GAP;
               else                   state <= S_SETTLE;
            end
            S_GAP: begin
               if (tmr_done) begin
                  state  <= S_STEP;
                  dly_ce <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (tmr_done) state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               rsp_tap <= dly_cntvalueout;
               rsp_err <= ((op == OP_LOAD) && (dly_cntvalueout != val))
                          | clamp;
               if (op == OP_READ) begin
                  state <= S_RESP;
               end else begin
                  state      <= S_VTC_ON;
                  dly_en_vtc <= 1'b1;
               end
            end
            S_VTC_ON: begin
               state <= S_RESP;
            end
            S_RESP: begin
               rsp_valid <= 1'b1;
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr4_phy_tri_dly_seq.sv
// Directed bench for the ODELAY tap sequencer with a behavioural bitslice.
// Drives and samples on the falling edge; pulses are logged on the rising edge.
module tb_ddr4_phy_tri_dly_seq;
   import ddr4_phy_tri_dly_pkg::*;

   localparam int TW = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [TW-1:0] req_val = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [TW-1:0] rsp_tap;
   logic          rsp_err;
   logic          dly_ce;
   logic          dly_inc;
   logic          dly_ld;
   logic [TW-1:0] dly_cntvaluein;
   logic [TW-1:0] dly_cntvalueout;
   logic          dly_en_vtc;
   logic          busy;

   always #5 clk = ~clk;

   ddr4_phy_tri_dly_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_val        (req_val),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_tap        (rsp_tap),
      .rsp_err        (rsp_err),
      .dly_ce         (dly_ce),
      .dly_inc        (dly_inc),
      .dly_ld         (dly_ld),
      .dly_cntvaluein (dly_cntvaluein),
      .dly_cntvalueout(dly_cntvalueout),
      .dly_en_vtc     (dly_en_vtc),
      .busy           (busy)
   );

   // Bitslice ODELAY tap model
   logic [TW-1:0] tap = '0;
   logic          set_en = 1'b0;
   logic [TW-1:0] set_val = '0;

   always @(posedge clk) begin
      if (set_en)      tap <= set_val;
      else if (dly_ld) tap <= dly_cntvaluein;
      else if (dly_ce) tap <= dly_inc ? tap + 1'b1 : tap - 1'b1;
   end

   assign dly_cntvalueout = tap;

   // Pulse log
   int cyc = 0;
   int n_ld = 0;
   int n_inc = 0;
   int n_dec = 0;
   int n_both = 0;
   int n_vtc_hi = 0;
   int n_vtc_lo = 0;
   int ld_val = 0;
   int ce_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!dly_en_vtc) n_vtc_lo <= n_vtc_lo + 1;
      if (dly_ce && dly_ld) n_both <= n_both + 1;
      if ((dly_ce || dly_ld) && dly_en_vtc) n_vtc_hi <= n_vtc_hi + 1;
      if (dly_ld) begin
         n_ld   <= n_ld + 1;
         ld_val <= int'(dly_cntvaluein);
      end
      if (dly_ce) begin
         ce_q.push_back(cyc);
         if (dly_inc) n_inc <= n_inc + 1;
         else         n_dec <= n_dec + 1;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic set_tap(input int v);
      @(negedge clk);
      set_en  = 1'b1;
      set_val = TW'(v);
      @(negedge clk);
      set_en  = 1'b0;
   endtask

   task automatic do_op(input dly_op_e o, input int v,
                        output int tap_o, output int err_o,
                        output int lat_o, output int vtc_o);
      int t;
      int acc;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = o;
      req_val   = TW'(v);
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("accept_timeout", 0, 1);
      @(negedge clk);
      acc       = cyc;
      req_valid = 1'b0;
      t = 0;
      while (!rsp_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
      lat_o = cyc - acc;
      tap_o = int'(rsp_tap);
      err_o = int'(rsp_err);
      vtc_o = int'(dly_en_vtc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int rt, re, rl, rv;
      int b_ld, b_lo, b_q, b_inc, b_dec;
      int t;

      // 1 reset
      repeat (3) @(negedge clk);
      chk("rst_en_vtc", int'(dly_en_vtc), 1);
      chk("rst_ce", int'(dly_ce), 0);
      chk("rst_ld", int'(dly_ld), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", int'(req_ready), 1);

      // 2 LOAD 100
      set_tap(0);
      b_ld = n_ld;
      b_lo = n_vtc_lo;
      do_op(OP_LOAD, 100, rt, re, rl, rv);
      chk("load_ld_cnt", n_ld - b_ld, 1);
      chk("load_ld_val", ld_val, 100);
      chk("load_tap", rt, 100);
      chk("load_err", re, 0);
      chk("load_lat", rl, 16);
      chk("load_vtc_rsp", rv, 1);
      chk("load_vtc_lo", n_vtc_lo - b_lo, 14);

      // 3 INC 5 from 20
      set_tap(20);
      b_q   = ce_q.size();
      b_inc = n_inc;
      b_lo  = n_vtc_lo;
      do_op(OP_INC, 5, rt, re, rl, rv);
      chk("inc_pulses", n_inc - b_inc, 5);
      if (ce_q.size() - b_q == 5) begin
         for (int i = 1; i < 5; i++)
            chk("inc_gap", ce_q[b_q+i] - ce_q[b_q+i-1], 4);
      end else begin
         chk("inc_q_size", ce_q.size() - b_q, 5);
      end
      chk("inc_tap", rt, 25);
      chk("inc_err", re, 0);
      chk("inc_lat", rl, 32);
      chk("inc_vtc_rsp", rv, 1);
      chk("inc_vtc_lo", n_vtc_lo - b_lo, 30);

      // 4 DEC 10 from 3, INC 8 from 508
      set_tap(3);
      b_dec = n_dec;
      do_op(OP_DEC, 10, rt, re, rl, rv);
      chk("dec_pulses", n_dec - b_dec, 3);
      chk("dec_tap", rt, 0);
      chk("dec_err", re, 1);
      chk("dec_lat", rl, 24);
      set_tap(508);
      b_inc = n_inc;
      do_op(OP_INC, 8, rt, re, rl, rv);
      chk("incmax_pulses", n_inc - b_inc, 3);
      chk("incmax_tap", rt, 511);
      chk("incmax_err", re, 1);

      // 5 READ 77 with backpressure
      set_tap(77);
      b_q  = ce_q.size();
      b_ld = n_ld;
      b_lo = n_vtc_lo;
      rsp_ready = 1'b0;
      do_op(OP_READ, 0, rt, re, rl, rv);
      chk("read_lat", rl, 2);
      chk("read_tap", rt, 77);
      chk("read_err", re, 0);
      req_valid = 1'b1;
      req_op    = OP_READ;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", int'(rsp_valid), 1);
         chk("hold_tap", int'(rsp_tap), 77);
         chk("hold_no_accept", int'(req_ready), 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("read_done_valid", int'(rsp_valid), 0);
      chk("read_done_ready", int'(req_ready), 1);
      chk("read_no_ce", ce_q.size() - b_q, 0);
      chk("read_no_ld", n_ld - b_ld, 0);
      chk("read_vtc_lo", n_vtc_lo - b_lo, 0);

      // 6 INC 0, then reset during INC 6
      set_tap(40);
      b_q = ce_q.size();
      do_op(OP_INC, 0, rt, re, rl, rv);
      chk("inc0_pulses", ce_q.size() - b_q, 0);
      chk("inc0_tap", rt, 40);
      chk("inc0_err", re, 0);
      chk("inc0_lat", rl, 15);

      set_tap(10);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_INC;
      req_val   = TW'(6);
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      b_q = ce_q.size();
      t = 0;
      while (ce_q.size() - b_q < 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("abort_pre_pulses", ce_q.size() - b_q, 2);
      chk("abort_pre_vtc", int'(dly_en_vtc), 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_vtc", int'(dly_en_vtc), 1);
      chk("abort_rsp", int'(rsp_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ce", int'(dly_ce), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", int'(rsp_valid), 0);
      end
      chk("abort_pulses", ce_q.size() - b_q, 2);
      do_op(OP_READ, 0, rt, re, rl, rv);
      chk("post_read_tap", rt, 12);
      chk("post_read_err", re, 0);
      chk("post_read_lat", rl, 2);

      @(negedge clk);
      chk("ce_ld_overlap", n_both, 0);
      chk("pulse_vtc_hi", n_vtc_hi, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
